// File: rtl/cf_fft_1024_8_ctrl_if.sv
// Control bundle between the FFT sequencer and its sample memory,
// butterfly unit, input source and result sink.
interface cf_fft_1024_8_ctrl_if;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic       bf_en;
    logic [9:0] bf_addr_a;
    logic [9:0] bf_addr_b;
    logic [8:0] tw_idx;
    logic [3:0] stage;
    logic       out_ready;
    logic       out_valid;
    logic [9:0] rd_addr;
    logic       busy;
    logic       done;

    modport master (
        input  start, in_valid, out_ready,
        output in_ready, wr_en, wr_addr,
        output bf_en, bf_addr_a, bf_addr_b, tw_idx, stage,
        output out_valid, rd_addr, busy, done
    );

    modport slave (
        output start, in_valid, out_ready,
        input  in_ready, wr_en, wr_addr,
        input  bf_en, bf_addr_a, bf_addr_b, tw_idx, stage,
        input  out_valid, rd_addr, busy, done
    );
endinterface

// File: rtl/cf_fft_1024_8_ctrl.sv
// Sequencer for a 1024-point radix-2 DIT FFT: bit-reversed load,
// 10 butterfly stages with pipeline drain, natural-order unload.
module cf_fft_1024_8_ctrl #(
    parameter int unsigned PIPE_LAT = 3,
    parameter int unsigned N_LOG2   = 10
) (
    input  logic                 clock_c,
    input  logic                 reset_n,
    cf_fft_1024_8_ctrl_if.master ctl
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DRAIN,
        UNLOAD
    } state_t;

    localparam logic [N_LOG2-1:0] K_LAST = '1;
    localparam logic [N_LOG2-2:0] J_LAST = '1;
    localparam logic [3:0]        S_LAST = 4'(N_LOG2 - 1);
    localparam logic [3:0]        D_LAST = 4'(PIPE_LAT - 1);

    state_t            state;
    logic [N_LOG2-1:0] k;
    logic [N_LOG2-2:0] j;
    logic [3:0]        s;
    logic [3:0]        d;

    always_ff @(posedge clock_c or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            k     <= '0;
            j     <= '0;
            s     <= '0;
            d     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ctl.start) begin
                        state <= LOAD;
                        k     <= '0;
                        s     <= '0;
                    end
                end
                LOAD: begin
                    if (ctl.in_valid) begin
                        k <= k + 1'b1;
                        if (k == K_LAST) begin
                            state <= COMPUTE;
                            s     <= '0;
                            j     <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    j <= j + 1'b1;
                    if (j == J_LAST) begin
                        state <= DRAIN;
                        d     <= '0;
                    end
                end
                DRAIN: begin
                    d <= d + 1'b1;
                    if (d == D_LAST) begin
                        d <= '0;
                        if (s == S_LAST) begin
                            state <= UNLOAD;
                            k     <= '0;
                        end else begin
                            state <= COMPUTE;
                            s     <= s + 1'b1;
                            j     <= '0;
                        end
                    end
                end
                UNLOAD: begin
                    if (ctl.out_ready) begin
                        k <= k + 1'b1;
                        if (k == K_LAST)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Group index moves up one bit to leave room for the span bit.
    logic [9:0] span;
    logic [9:0] mask;
    logic [9:0] pos;
    logic [9:0] addr_a;
    logic [8:0] tw;
    logic [9:0] k_rev;

    always_comb begin
        span   = 10'd1 << s;
        mask   = span - 10'd1;
        pos    = {1'b0, j} & mask;
        addr_a = (({1'b0, j} & ~mask) << 1) | pos;
        tw     = 9'(pos << (4'd9 - s));
        k_rev  = '0;
        for (int i = 0; i < 10; i++)
            k_rev[i] = k[9 - i];
    end

    always_comb begin
        ctl.in_ready  = (state == LOAD);
        ctl.wr_en     = ctl.in_ready & ctl.in_valid;
        ctl.wr_addr   = ctl.in_ready ? k_rev : '0;
        ctl.bf_en     = (state == COMPUTE);
        ctl.bf_addr_a = ctl.bf_en ? addr_a : '0;
        ctl.bf_addr_b = ctl.bf_en ? (addr_a | span) : '0;
        ctl.tw_idx    = ctl.bf_en ? tw : '0;
        ctl.stage     = s;
        ctl.out_valid = (state == UNLOAD);
        ctl.rd_addr   = ctl.out_valid ? k : '0;
        ctl.busy      = (state != IDLE);
        ctl.done      = ctl.out_valid & ctl.out_ready & (k == K_LAST);
    end
endmodule

// File: tb/tb_cf_fft_1024_8_ctrl.sv
// Scoreboard bench for the FFT sequencer: expected load, butterfly
// and unload streams are queued up front and popped by a monitor.
module tb_cf_fft_1024_8_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cf_fft_1024_8_ctrl_if f0 ();
    cf_fft_1024_8_ctrl_if f1 ();

    cf_fft_1024_8_ctrl #(.PIPE_LAT(3)) dut0 (
        .clock_c(clk),
        .reset_n(rst_n),
        .ctl    (f0)
    );

    cf_fft_1024_8_ctrl #(.PIPE_LAT(1)) dut1 (
        .clock_c(clk),
        .reset_n(rst_n),
        .ctl    (f1)
    );

    typedef struct {
        int st;
        int a;
        int b;
        int tw;
    } bf_t;

    typedef struct {
        int addr;
        int dn;
    } ul_t;

    int  checks = 0;
    int  fails  = 0;
    int  lq[$];
    bf_t bq[$];
    ul_t uq[$];

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    function automatic int rev10(int x);
        int r = 0;
        for (int i = 0; i < 10; i++)
            r = (r << 1) | ((x >> i) & 1);
        return r;
    endfunction

    task automatic push_load();
        for (int i = 0; i < 1024; i++)
            lq.push_back(rev10(i));
    endtask

    task automatic push_bf();
        bf_t e;
        for (int st = 0; st < 10; st++) begin
            int sp = 1 << st;
            for (int g = 0; g < 1024; g += 2 * sp)
                for (int p = 0; p < sp; p++) begin
                    e.st = st;
                    e.a  = g + p;
                    e.b  = g + p + sp;
                    e.tw = p * (512 / sp);
                    bq.push_back(e);
                end
        end
    endtask

    task automatic push_unload();
        ul_t e;
        for (int i = 0; i < 1024; i++) begin
            e.addr = i;
            e.dn   = (i == 1023) ? 1 : 0;
            uq.push_back(e);
        end
    endtask

    // Hand-computed butterfly points
    int hs[3] = '{0, 3, 9};
    int hj[3] = '{5, 13, 300};
    int ha[3] = '{10, 21, 300};
    int hb[3] = '{11, 29, 812};
    int ht[3] = '{0, 320, 300};

    int ms = 15;
    int bj = 0;
    int gap = 0;
    bit seen = 0;
    bit gap_en = 0;

    always @(negedge clk) begin
        if (int'(f0.wr_en) + int'(f0.bf_en) + int'(f0.out_valid) > 1)
            chk("excl", 1, 0);
        if (f0.wr_en) begin
            if (lq.size() == 0) chk("wr_extra", 1, 0);
            else chk("wr_addr", f0.wr_addr, lq.pop_front());
        end
        if (f0.bf_en) begin
            bf_t e;
            if (int'(f0.stage) != ms) begin
                ms = f0.stage;
                bj = 0;
            end
            for (int i = 0; i < 3; i++)
                if (ms == hs[i] && bj == hj[i]) begin
                    chk("hand_a", f0.bf_addr_a, ha[i]);
                    chk("hand_b", f0.bf_addr_b, hb[i]);
                    chk("hand_tw", f0.tw_idx, ht[i]);
                end
            bj++;
            if (bq.size() == 0) chk("bf_extra", 1, 0);
            else begin
                e = bq.pop_front();
                checks++;
                if (f0.stage !== 4'(e.st) || f0.bf_addr_a !== 10'(e.a) ||
                    f0.bf_addr_b !== 10'(e.b) || f0.tw_idx !== 9'(e.tw)) begin
                    fails++;
                    $display("FAIL bf: got s%0d a%0d b%0d t%0d expected s%0d a%0d b%0d t%0d",
                             f0.stage, f0.bf_addr_a, f0.bf_addr_b, f0.tw_idx,
                             e.st, e.a, e.b, e.tw);
                end
            end
        end
        if (f0.out_valid && f0.out_ready) begin
            ul_t e;
            if (uq.size() == 0) chk("ul_extra", 1, 0);
            else begin
                e = uq.pop_front();
                chk("rd_addr", f0.rd_addr, e.addr);
                chk("done", f0.done, e.dn);
            end
        end else if (f0.done) begin
            chk("done_nohs", 1, 0);
        end
        if (gap_en) begin
            if (f0.bf_en) begin
                if (gap > 0) chk("drain_gap", gap, 3);
                gap  = 0;
                seen = 1;
            end else if (seen && !f0.out_valid) begin
                gap++;
            end else if (seen && f0.out_valid) begin
                chk("drain_last", gap, 3);
                gap  = 0;
                seen = 0;
            end
        end
    end

    int pat[4] = '{1, 0, 0, 1};

    initial begin
        int acc;
        int cyc;
        int t;
        int dn;
        int hl[5] = '{0, 512, 256, 768, 128};
        bit stalled;
        bit last_stall;
        logic [9:0] last_addr;

        rst_n = 1'b0;
        f0.start = 0; f0.in_valid = 0; f0.out_ready = 0;
        f1.start = 0; f1.in_valid = 0; f1.out_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", f0.busy, 0);
        chk("rst_in_ready", f0.in_ready, 0);
        chk("rst_bf_en", f0.bf_en, 0);
        chk("rst_out_valid", f0.out_valid, 0);
        chk("rst_stage", f0.stage, 0);
        chk("rst_done", f0.done, 0);
        @(posedge clk) #1 rst_n = 1'b1;

        // Full transform on the PIPE_LAT=3 instance
        push_load();
        push_bf();
        push_unload();
        gap_en = 1;
        @(posedge clk) #1 f0.start = 1;
        @(posedge clk) #1 f0.start = 0;
        f0.in_valid = 1;
        acc = 0; cyc = 0; stalled = 0;
        while (acc < 1024 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (f0.wr_en) begin
                if (acc < 5) chk("load_order", f0.wr_addr, hl[acc]);
                if (acc == 1023) chk("load_last", f0.wr_addr, 1023);
                acc++;
            end
            if (acc == 100 && !stalled) begin
                stalled = 1;
                @(posedge clk) #1 f0.in_valid = 0;
                repeat (20) begin
                    @(negedge clk);
                    chk("stall_wr_en", f0.wr_en, 0);
                    chk("stall_addr", f0.wr_addr, 152);
                end
                @(posedge clk) #1 f0.in_valid = 1;
            end else begin
                @(posedge clk) #1;
            end
        end
        chk("load_count", acc, 1024);
        f0.in_valid = 0;
        @(negedge clk);
        chk("compute_entry", f0.bf_en, 1);
        chk("compute_in_ready", f0.in_ready, 0);
        t = 0;
        while (!f0.out_valid && t < 6000) begin
            @(posedge clk) #1;
            if (t == 100) f0.start = 1;
            if (t == 103) f0.start = 0;
            @(negedge clk);
            t++;
        end
        chk("compute_cycles_3", t, 5150);

        dn = 0; cyc = 0; last_stall = 0; last_addr = '0;
        while (dn == 0 && cyc < 3000) begin
            @(posedge clk) #1 f0.out_ready = pat[cyc % 4][0];
            @(negedge clk);
            if (last_stall) chk("rd_hold", f0.rd_addr, last_addr);
            last_stall = !f0.out_ready;
            last_addr  = f0.rd_addr;
            if (f0.done) begin
                dn++;
                chk("done_addr", f0.rd_addr, 1023);
            end
            cyc++;
        end
        chk("done_seen", dn, 1);
        @(posedge clk) #1 f0.out_ready = 0;
        @(negedge clk);
        chk("end_busy", f0.busy, 0);
        chk("end_out_valid", f0.out_valid, 0);
        chk("end_done", f0.done, 0);
        gap_en = 0;
        chk("lq_empty", lq.size(), 0);
        chk("bq_empty", bq.size(), 0);
        chk("uq_empty", uq.size(), 0);

        // Reset in the middle of stage 4
        push_load();
        push_bf();
        @(posedge clk) #1 f0.start = 1;
        @(posedge clk) #1 f0.start = 0;
        f0.in_valid = 1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(f0.bf_en && f0.stage == 4'd4) && cyc < 8000);
        chk("reach_stage4", f0.stage, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_busy", f0.busy, 0);
        chk("mid_bf_en", f0.bf_en, 0);
        chk("mid_addr_a", f0.bf_addr_a, 0);
        chk("mid_tw", f0.tw_idx, 0);
        chk("mid_stage", f0.stage, 0);
        chk("mid_in_ready", f0.in_ready, 0);
        f0.in_valid = 0;
        lq.delete();
        bq.delete();
        @(posedge clk) #1 rst_n = 1'b1;
        @(posedge clk) #1 f0.start = 1;
        @(posedge clk) #1 f0.start = 0;
        @(negedge clk);
        chk("reload_ready", f0.in_ready, 1);
        chk("reload_addr", f0.wr_addr, 0);
        chk("reload_wr_en", f0.wr_en, 0);
        lq.push_back(0);
        @(posedge clk) #1 f0.in_valid = 1;
        @(posedge clk) #1 f0.in_valid = 0;
        @(negedge clk);
        chk("reload_next", f0.wr_addr, 512);
        chk("reload_lq", lq.size(), 0);

        // Timing on the PIPE_LAT=1 instance
        @(posedge clk) #1 f1.start = 1;
        @(posedge clk) #1 f1.start = 0;
        f1.in_valid = 1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!f1.bf_en && cyc < 3000);
        f1.in_valid = 0;
        chk("p1_bf_en", f1.bf_en, 1);
        t = 0;
        while (!f1.out_valid && t < 6000) begin
            @(negedge clk);
            t++;
        end
        chk("compute_cycles_1", t, 5130);
        @(posedge clk) #1 f1.out_ready = 1;
        acc = 0; cyc = 0; dn = 0;
        while (dn == 0 && cyc < 2000) begin
            @(negedge clk);
            if (f1.out_valid && f1.out_ready) acc++;
            if (f1.done) dn++;
            cyc++;
        end
        chk("p1_unload_count", acc, 1024);
        @(posedge clk) #1 f1.out_ready = 0;
        @(negedge clk);
        chk("p1_busy", f1.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
